// File: rtl/wb_resolve_unit.sv
// rtl/wb_resolve_unit.sv - lc3b writeback/resolve stage with CC register, branch redirect and squash FSM (optional WB_PERF_CNT_EN counters)
module wb_resolve_unit #(
   parameter int WIDTH       = 16,
   parameter int REGW        = 3,
   parameter int NUM_SRC     = 4,
   parameter int SELW        = 2,
   parameter int FLUSH_DEPTH = 3,
   parameter int CNTW        = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_in,
   input  logic                     stall,
   input  logic [SELW-1:0]          src_sel,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic [REGW-1:0]          dr_in,
   input  logic                     load_regfile_in,
   input  logic                     load_cc_in,
   input  logic                     is_br,
   input  logic                     is_jmp,
   input  logic [2:0]               nzp,
   input  logic [WIDTH-1:0]         br_target,
   output logic [WIDTH-1:0]         wbdata,
   output logic [REGW-1:0]          wbdr,
   output logic                     load_regfile,
   output logic [2:0]               cc_out,
   output logic                     redirect,
   output logic [WIDTH-1:0]         redirect_pc,
   output logic                     flush,
   output logic                     flush_busy,
   output logic [CNTW-1:0]          retired_cnt,
   output logic [CNTW-1:0]          taken_cnt
);

   localparam int CW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

   typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    cc_q;
   logic          act;
   logic          taken;
   logic          in_squash;

   // {n,z,p} from a writeback value; exactly one bit is ever set
   function automatic logic [2:0] gencc(input logic [WIDTH-1:0] d);
      if (d[WIDTH-1])      return 3'b100;
      else if (d == '0)    return 3'b010;
      else                 return 3'b001;
   endfunction

   // Source mux; selects beyond NUM_SRC read as zero
   always_comb begin
      wbdata = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (src_sel == SELW'(k)) wbdata = src_data[k*WIDTH +: WIDTH];
      end
   end

   assign wbdr        = dr_in;
   assign redirect_pc = br_target;
   assign cc_out      = cc_q;

   // A packet only acts in RUN, unstalled and out of reset; taken uses the CC before this packet's update
   assign in_squash = (state_q == SQUASH) & ~reset;
   assign act       = valid_in & ~stall & (state_q == RUN) & ~reset;
   assign taken     = is_jmp | (is_br & |(nzp & cc_q));

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state: a redirect opens a window of FLUSH_DEPTH unstalled squash cycles
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (act & taken) begin
               state_d = SQUASH;
               cnt_d   = CW'(FLUSH_DEPTH - 1);
            end
         end
         SQUASH: begin
            if (!stall) begin
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CW'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   // FSM outputs
   always_comb begin
      redirect     = act & taken;
      load_regfile = act & load_regfile_in;
      flush_busy   = in_squash;
      flush        = (act & taken) | in_squash;
   end

   // Architectural condition codes
   always_ff @(posedge clk) begin
      if (reset)                  cc_q <= 3'b010;
      else if (act & load_cc_in)  cc_q <= gencc(wbdata);
   end

`ifdef WB_PERF_CNT_EN
   logic [CNTW-1:0] retired_q, taken_q;

   // Retire/redirect counters, wrapping modulo 2**CNTW
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_q <= '0;
         taken_q   <= '0;
      end else begin
         if (act)         retired_q <= retired_q + CNTW'(1);
         if (act & taken) taken_q   <= taken_q + CNTW'(1);
      end
   end

   assign retired_cnt = retired_q;
   assign taken_cnt   = taken_q;
`else
   assign retired_cnt = '0;
   assign taken_cnt   = '0;
`endif

endmodule

// File: tb/tb_wb_resolve_unit.sv
// tb/tb_wb_resolve_unit.sv - self-checking bench for wb_resolve_unit
module tb_wb_resolve_unit;

   localparam int WIDTH = 16;
   localparam int NSRC  = 3;
   localparam int FD    = 3;
   localparam int CNTW  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              valid_in = 1'b0;
   logic              stall = 1'b0;
   logic [1:0]        src_sel = '0;
   logic [NSRC*16-1:0] src_data = '0;
   logic [2:0]        dr_in = '0;
   logic              load_regfile_in = 1'b0;
   logic              load_cc_in = 1'b0;
   logic              is_br = 1'b0;
   logic              is_jmp = 1'b0;
   logic [2:0]        nzp = '0;
   logic [15:0]       br_target = '0;
   logic [15:0]       wbdata;
   logic [2:0]        wbdr;
   logic              load_regfile;
   logic [2:0]        cc_out;
   logic              redirect;
   logic [15:0]       redirect_pc;
   logic              flush;
   logic              flush_busy;
   logic [CNTW-1:0]   retired_cnt;
   logic [CNTW-1:0]   taken_cnt;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   // model state: CC, remaining unstalled squash cycles, perf counts
   logic [2:0] m_cc = 3'b010;
   int         m_sq = 0;
   int         m_ret = 0;
   int         m_tkn = 0;

   wb_resolve_unit #(.WIDTH(WIDTH), .REGW(3), .NUM_SRC(NSRC), .SELW(2),
                     .FLUSH_DEPTH(FD), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall),
      .src_sel(src_sel), .src_data(src_data), .dr_in(dr_in),
      .load_regfile_in(load_regfile_in), .load_cc_in(load_cc_in),
      .is_br(is_br), .is_jmp(is_jmp), .nzp(nzp), .br_target(br_target),
      .wbdata(wbdata), .wbdr(wbdr), .load_regfile(load_regfile),
      .cc_out(cc_out), .redirect(redirect), .redirect_pc(redirect_pc),
      .flush(flush), .flush_busy(flush_busy),
      .retired_cnt(retired_cnt), .taken_cnt(taken_cnt));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      total++;
      if (act_v !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act_v, exp_v, $time);
      end
   endtask

   function automatic logic [15:0] m_wb();
      logic [NSRC*16-1:0] t;
      if (int'(src_sel) >= NSRC) return 16'h0;
      t = src_data >> (int'(src_sel) * 16);
      return t[15:0];
   endfunction

   function automatic logic [2:0] m_gencc(input logic [15:0] d);
      if (d >= 16'h8000) return 3'b100;
      if (d == 16'h0)    return 3'b010;
      return 3'b001;
   endfunction

   function automatic bit m_act();
      return valid_in && !stall && m_sq == 0 && !reset;
   endfunction

   function automatic bit m_taken();
      return is_jmp || (is_br && ((nzp & m_cc) != 3'b000));
   endfunction

   // model update on each clock
   always @(posedge clk) begin
      if (reset) begin
         m_cc = 3'b010; m_sq = 0; m_ret = 0; m_tkn = 0;
      end else if (m_sq > 0) begin
         if (!stall) m_sq--;
      end else if (m_act()) begin
         m_ret++;
         if (m_taken()) begin
            m_sq = FD;
            m_tkn++;
         end
         if (load_cc_in) m_cc = m_gencc(m_wb());
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (check_en) begin
         bit a, rd, sq;
         a  = m_act();
         rd = a && m_taken();
         sq = (m_sq > 0) && !reset;
         check("wbdata", 32'(wbdata), 32'(m_wb()));
         check("wbdr", 32'(wbdr), 32'(dr_in));
         check("redirect_pc", 32'(redirect_pc), 32'(br_target));
         check("load_regfile", 32'(load_regfile), 32'(a && load_regfile_in));
         check("cc_out", 32'(cc_out), 32'(m_cc));
         check("redirect", 32'(redirect), 32'(rd));
         check("flush", 32'(flush), 32'(rd || sq));
         check("flush_busy", 32'(flush_busy), 32'(sq));
`ifdef WB_PERF_CNT_EN
         check("retired_cnt", 32'(retired_cnt), 32'(m_ret % 16));
         check("taken_cnt", 32'(taken_cnt), 32'(m_tkn % 16));
`else
         check("retired_cnt", 32'(retired_cnt), 32'(0));
         check("taken_cnt", 32'(taken_cnt), 32'(0));
`endif
      end
   end

   task automatic step(input logic rst, input logic v, input logic st, input logic [1:0] sel,
                       input logic [15:0] d0, input logic lrf, input logic lcc,
                       input logic br, input logic jmp, input logic [2:0] n, input logic [15:0] tgt);
      @(posedge clk); #1;
      reset = rst; valid_in = v; stall = st; src_sel = sel;
      src_data = {16'h5a5a, 16'h1234, d0}; dr_in = d0[2:0];
      load_regfile_in = lrf; load_cc_in = lcc; is_br = br; is_jmp = jmp;
      nzp = n; br_target = tgt;
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 3'b000, 16'h0);
   endtask

   int fcount;

   initial begin
      step(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 3'b000, 16'h0);
      check_en = 1'b1;
      step(1, 1, 0, 0, 16'h8001, 1, 1, 0, 1, 3'b111, 16'h1111);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_load_regfile", 32'(load_regfile), 32'd0);

      // 1: ALU op, negative result
      step(0, 1, 0, 0, 16'h8001, 1, 1, 0, 0, 3'b000, 16'h0);
      check("t1_wbdata", 32'(wbdata), 32'h8001);
      check("t1_load_regfile", 32'(load_regfile), 32'd1);
      check("t1_cc_before", 32'(cc_out), 32'b010);
      idle();
      check("t1_cc_after", 32'(cc_out), 32'b100);

      // other sources, stall in RUN, out-of-range select
      step(0, 1, 0, 1, 16'h0, 1, 0, 0, 0, 3'b000, 16'h0);
      check("sel1_wbdata", 32'(wbdata), 32'h1234);
      step(0, 1, 1, 0, 16'h0005, 1, 1, 0, 1, 3'b111, 16'h2222);
      check("stall_load_regfile", 32'(load_regfile), 32'd0);
      check("stall_redirect", 32'(redirect), 32'd0);
      idle();
      check("stall_cc_hold", 32'(cc_out), 32'b100);
      step(0, 1, 0, 3, 16'hffff, 1, 1, 0, 0, 3'b000, 16'h0);
      check("sel3_wbdata", 32'(wbdata), 32'h0);

      // 2: BR z taken; flush for 1+FD cycles. 3: squashed packets discarded
      idle();
      check("t2_cc", 32'(cc_out), 32'b010);
      step(0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 3'b010, 16'h3000);
      check("t2_redirect", 32'(redirect), 32'd1);
      check("t2_redirect_pc", 32'(redirect_pc), 32'h3000);
      fcount = int'(flush);
      for (int i = 0; i < FD; i++) begin
         step(0, 1, 0, 0, 16'h8001, 1, 1, 1, 0, 3'b111, 16'h4444);
         check("t3_sq_load_regfile", 32'(load_regfile), 32'd0);
         check("t3_sq_redirect", 32'(redirect), 32'd0);
         fcount += int'(flush);
      end
      step(0, 1, 0, 0, 16'h0007, 1, 0, 0, 0, 3'b000, 16'h0);
      fcount += int'(flush);
      check("t2_flush_cycles", 32'(fcount), 32'd4);
      check("t3_cc_unchanged", 32'(cc_out), 32'b010);
      check("t3_resume_write", 32'(load_regfile), 32'd1);

      // BR not taken
      step(0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 3'b101, 16'h5000);
      check("br_not_taken", 32'(redirect), 32'd0);

      // 4: stall mid-squash
      step(0, 1, 0, 0, 16'h0, 0, 0, 0, 1, 3'b000, 16'h6000);
      check("t4_redirect", 32'(redirect), 32'd1);
      fcount = int'(flush);
      step(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 3'b000, 16'h0);
      fcount += int'(flush);
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 1, 0, 16'h0, 1, 1, 0, 0, 3'b000, 16'h0);
         check("t4_stall_busy", 32'(flush_busy), 32'd1);
         fcount += int'(flush);
      end
      for (int i = 0; i < 3; i++) begin
         idle();
         fcount += int'(flush);
      end
      check("t4_flush_cycles", 32'(fcount), 32'd6);
      check("t4_busy_done", 32'(flush_busy), 32'd0);

      // 5: reset during squash with cnt=1
      step(0, 1, 0, 0, 16'h8001, 1, 1, 0, 0, 3'b000, 16'h0);
      step(0, 1, 0, 0, 16'h0, 1, 0, 0, 1, 3'b000, 16'h7000);
      check("t5_jsr_write", 32'(load_regfile), 32'd1);
      check("t5_jsr_redirect", 32'(redirect), 32'd1);
      idle();
      step(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 3'b000, 16'h0);
      idle();
      check("t5_flush", 32'(flush), 32'd0);
      check("t5_busy", 32'(flush_busy), 32'd0);
      check("t5_cc", 32'(cc_out), 32'b010);

      // 6: counter wrap and redirect count
      for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 16'(i + 1), 1, 1, 0, 0, 3'b000, 16'h0);
      idle();
`ifdef WB_PERF_CNT_EN
      check("t6_retired_wrap", 32'(retired_cnt), 32'd1);
`endif
      for (int j = 0; j < 2; j++) begin
         step(0, 1, 0, 0, 16'h0, 0, 0, 0, 1, 3'b000, 16'h8000);
         for (int i = 0; i < FD; i++) idle();
      end
      idle();
`ifdef WB_PERF_CNT_EN
      check("t6_taken", 32'(taken_cnt), 32'd2);
      check("t6_retired", 32'(retired_cnt), 32'd3);
`else
      check("t6_taken_tied", 32'(taken_cnt), 32'd0);
`endif
      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
